// File: rtl/user_pkg.sv
// Shared types and constants for the user domain: OBI subordinate types,
// external IRQ count, demux indices and the GPIO interrupt register map.
package user_pkg;

  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam int unsigned SbrIdWidth = 4;
  localparam obi_cfg_t SbrObiCfg = '{AddrWidth: 32, DataWidth: 32, IdWidth: SbrIdWidth};

  typedef struct packed {
    logic [31:0]           addr;
    logic                  we;
    logic [3:0]            be;
    logic [31:0]           wdata;
    logic [SbrIdWidth-1:0] aid;
  } sbr_obi_a_chan_t;

  typedef struct packed {
    sbr_obi_a_chan_t a;
    logic            req;
  } sbr_obi_req_t;

  typedef struct packed {
    logic [31:0]           rdata;
    logic [SbrIdWidth-1:0] rid;
    logic                  err;
  } sbr_obi_r_chan_t;

  typedef struct packed {
    sbr_obi_r_chan_t r;
    logic            gnt;
    logic            rvalid;
  } sbr_obi_rsp_t;

  localparam int unsigned NumExternalIrqs = 4;

  // User-domain demux: the GPIO interrupt block sits next to the error subordinate.
  typedef enum int {
    UserError   = 0,
    UserGpioIrq = 1
  } user_demux_outputs_e;

  localparam int unsigned NumUserDomainSubordinates = 2;
  localparam logic [31:0] UserGpioIrqAddrOffset     = 32'h2000_1000;
  localparam logic [31:0] UserGpioIrqAddrRange      = 32'h0000_1000;

  localparam logic [2:0] GpioIrqOffEn      = 3'd0;
  localparam logic [2:0] GpioIrqOffMode0   = 3'd1;
  localparam logic [2:0] GpioIrqOffMode1   = 3'd2;
  localparam logic [2:0] GpioIrqOffPending = 3'd3;
  localparam logic [2:0] GpioIrqOffGpioIn  = 3'd4;

  typedef enum logic [1:0] {
    GpioIrqRise  = 2'b00,
    GpioIrqFall  = 2'b01,
    GpioIrqBoth  = 2'b10,
    GpioIrqLevel = 2'b11
  } gpio_irq_mode_e;

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  // Channels folded onto interrupt line k: every c with c % num_irqs == k.
  function automatic logic [31:0] irq_group_mask(input int k, input int num_irqs,
                                                 input int gpio_count);
    logic [31:0] m;
    m = '0;
    for (int c = 0; c < 32; c++)
      if (c < gpio_count && (c % num_irqs) == k) m[c] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/user_gpio_irq_chan.sv
// One GPIO interrupt channel: mode-selected event detect and sticky pending flag.
module user_gpio_irq_chan
  import user_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           in_lvl,
  input  logic           in_prev,
  input  gpio_irq_mode_e mode,
  input  logic           en,
  input  logic           clr,
  output logic           pending
);

  logic evt;

  always_comb begin
    evt = 1'b0;
    unique case (mode)
      GpioIrqRise:  evt = in_lvl & ~in_prev;
      GpioIrqFall:  evt = ~in_lvl & in_prev;
      GpioIrqBoth:  evt = in_lvl ^ in_prev;
      GpioIrqLevel: evt = in_lvl;
      default:      evt = 1'b0;
    endcase
  end

  // A new event beats a simultaneous software clear so no edge is lost.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending <= 1'b0;
    end else if (evt && en) begin
      pending <= 1'b1;
    end else if (clr) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/user_gpio_irq.sv
// GPIO edge/level interrupt controller on an OBI subordinate port; channels
// are folded round-robin onto NumIrqs level interrupt lines.
module user_gpio_irq
  import user_pkg::*;
#(
  parameter obi_cfg_t    ObiCfg    = SbrObiCfg,
  parameter type         obi_req_t = sbr_obi_req_t,
  parameter type         obi_rsp_t = sbr_obi_rsp_t,
  parameter int unsigned GpioCount = 16,
  parameter int unsigned NumIrqs   = NumExternalIrqs
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  obi_req_t             obi_req_i,
  output obi_rsp_t             obi_rsp_o,
  input  logic [GpioCount-1:0] gpio_in_sync_i,
  output logic [NumIrqs-1:0]   irq_o
);

  logic [2:0]  off;
  logic        bad_off, wr_ok;
  logic [31:0] bmask, wdata_m;

  logic [GpioCount-1:0]   gpio_q, en_q, en_d, pending, pend_clr, active;
  logic [2*GpioCount-1:0] mode_q, mode_d;
  logic [63:0]            mode_ext, mode_wr;
  logic [31:0]            en_ext, en_wr;

  logic [ObiCfg.DataWidth-1:0] rdata_d, rdata_q;
  logic [ObiCfg.IdWidth-1:0]   rid_q;
  logic                        rvalid_q, err_q;

  assign off     = obi_req_i.a.addr[4:2];
  assign bad_off = off > GpioIrqOffGpioIn;
  assign wr_ok   = obi_req_i.req & obi_req_i.a.we & ~bad_off;
  assign bmask   = be_mask(obi_req_i.a.be);
  assign wdata_m = obi_req_i.a.wdata & bmask;

  // Registers are held only for implemented channels; the padded views make
  // the unimplemented bits read as zero and swallow writes.
  always_comb begin
    mode_ext = 64'(mode_q);
    en_ext   = 32'(en_q);
    en_wr    = en_ext;
    mode_wr  = mode_ext;
    if (wr_ok && off == GpioIrqOffEn)    en_wr          = (en_ext & ~bmask) | wdata_m;
    if (wr_ok && off == GpioIrqOffMode0) mode_wr[31:0]  = (mode_ext[31:0] & ~bmask) | wdata_m;
    if (wr_ok && off == GpioIrqOffMode1) mode_wr[63:32] = (mode_ext[63:32] & ~bmask) | wdata_m;
    en_d     = en_wr[GpioCount-1:0];
    mode_d   = mode_wr[2*GpioCount-1:0];
    pend_clr = (wr_ok && off == GpioIrqOffPending) ? wdata_m[GpioCount-1:0] : '0;
  end

  always_comb begin
    rdata_d = '0;
    if (!obi_req_i.a.we && !bad_off) begin
      case (off)
        GpioIrqOffEn:      rdata_d = en_ext;
        GpioIrqOffMode0:   rdata_d = mode_ext[31:0];
        GpioIrqOffMode1:   rdata_d = mode_ext[63:32];
        GpioIrqOffPending: rdata_d = 32'(pending);
        GpioIrqOffGpioIn:  rdata_d = 32'(gpio_q);
        default:           rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q   <= '0;
      mode_q <= '0;
      gpio_q <= '0;
    end else begin
      en_q   <= en_d;
      mode_q <= mode_d;
      gpio_q <= gpio_in_sync_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rid_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= obi_req_i.req;
      if (obi_req_i.req) begin
        rid_q   <= obi_req_i.a.aid;
        rdata_q <= rdata_d;
        err_q   <= bad_off;
      end
    end
  end

  always_comb begin
    obi_rsp_o         = '0;
    obi_rsp_o.gnt     = obi_req_i.req;
    obi_rsp_o.rvalid  = rvalid_q;
    obi_rsp_o.r.rdata = rdata_q;
    obi_rsp_o.r.rid   = rid_q;
    obi_rsp_o.r.err   = err_q;
  end

  for (genvar c = 0; c < GpioCount; c++) begin : g_chan
    user_gpio_irq_chan u_chan (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .in_lvl  (gpio_in_sync_i[c]),
      .in_prev (gpio_q[c]),
      .mode    (gpio_irq_mode_e'(mode_q[2*c +: 2])),
      .en      (en_q[c]),
      .clr     (pend_clr[c]),
      .pending (pending[c])
    );
  end

  assign active = pending & en_q;

  for (genvar k = 0; k < NumIrqs; k++) begin : g_irq
    localparam logic [31:0] GroupMask = irq_group_mask(k, NumIrqs, GpioCount);
    assign irq_o[k] = |(32'(active) & GroupMask);
  end

  logic unused_bits;
  assign unused_bits = ^{obi_req_i.a.addr, en_wr, mode_wr};

endmodule
